// File: rtl/hk_pkg.sv
// Shared definitions for the housekeeping register block: register addresses
// and the readback controller state encoding.
package hk_pkg;

    localparam logic [23:0] HK_ADDR_LED      = 24'h000001;
    localparam logic [23:0] HK_ADDR_WRSRC    = 24'h000002;
    localparam logic [23:0] HK_ADDR_RDBK_CNT = 24'h000003;
    localparam logic [23:0] HK_ADDR_RDBK_TMO = 24'h000004;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } hk_state_e;

endpackage

// File: rtl/hk_timeout_cnt.sv
// Saturating stall counter for the readback engine; flags the edge on which
// the count reaches a nonzero limit.
module hk_timeout_cnt
    import hk_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Fires on the edge that carries the count onto the limit, so the abort
    // lands exactly 'limit' stalled cycles after the last clear.
    assign hit = en && !clr && (limit != '0) && (cnt_d == limit);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hk_readback_ctrl.sv
// Readback controller: turns the FT245 bus around and pops a programmed
// number of bytes from the readback FIFO. Define HK_READBACK_DRAIN_EN to let
// a count of 32'hFFFFFFFF drain the FIFO until it runs empty.
module hk_readback_ctrl
    import hk_pkg::*;
#(
    parameter int TMO_W = 32,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             ARstn,
    input  logic             CfgValid,
    input  logic [23:0]      CfgAddr,
    input  logic [31:0]      CfgData,
    input  logic             FifoEmpty,
    input  logic             RdyWr,
    output logic             FifoRen,
    output logic             RWn,
    output logic             Busy,
    output logic             TimeoutErr,
    output logic [CNT_W-1:0] Remaining
);

    hk_state_e        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             drain_q, drain_d;

    logic cnt_wr, tmo_wr, cnt_zero, drain_sel, abort;
    logic in_xfer, pop, tmo_hit;

    assign cnt_wr   = CfgValid && (CfgAddr == HK_ADDR_RDBK_CNT);
    assign tmo_wr   = CfgValid && (CfgAddr == HK_ADDR_RDBK_TMO);
    assign cnt_zero = (CfgData == 32'h0);
    assign abort    = cnt_wr && cnt_zero && (state_q != IDLE);

`ifdef HK_READBACK_DRAIN_EN
    assign drain_sel = (CfgData == 32'hFFFF_FFFF);
`else
    assign drain_sel = 1'b0;
`endif

    assign in_xfer = (state_q == XFER);
    assign pop     = in_xfer && !FifoEmpty && RdyWr && (rem_q != '0);

    hk_timeout_cnt #(
        .W (TMO_W)
    ) u_tmo (
        .clk   (Clk),
        .rst_n (ARstn),
        .clr   (pop || (state_q == TURN)),
        .en    (in_xfer && !pop),
        .limit (tmo_q),
        .hit   (tmo_hit)
    );

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cnt_wr && !cnt_zero) state_d = TURN;
            TURN: state_d = XFER;
            XFER: begin
                if (tmo_hit) begin
                    state_d = IDLE;
                end else if (drain_q ? FifoEmpty : (pop && (rem_q == CNT_W'(1)))) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A zero count write aborts from any busy state, even over a pop.
        if (abort) state_d = IDLE;
    end

    always_comb begin
        FifoRen    = pop;
        RWn        = (state_q == IDLE);
        Busy       = (state_q != IDLE);
        TimeoutErr = err_q;
        Remaining  = rem_q;
    end

    always_comb begin
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        drain_d = drain_q;
        if (tmo_wr) tmo_d = TMO_W'(CfgData);
        if ((state_q == IDLE) && cnt_wr && !cnt_zero) begin
            rem_d   = CNT_W'(CfgData);
            err_d   = 1'b0;
            drain_d = drain_sel;
        end else if (abort) begin
            rem_d = '0;
        end else if (tmo_hit) begin
            err_d = 1'b1;
            rem_d = '0;
        end else if (pop && !drain_q) begin
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            rem_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_hk_readback_ctrl.sv
// Directed bench for hk_readback_ctrl with a counting FIFO model.
module tb_hk_readback_ctrl;

    logic        Clk      = 1'b0;
    logic        ARstn    = 1'b0;
    logic        CfgValid = 1'b0;
    logic [23:0] CfgAddr  = '0;
    logic [31:0] CfgData  = '0;
    logic        RdyWr    = 1'b0;
    logic        FifoEmpty;
    logic        FifoRen;
    logic        RWn;
    logic        Busy;
    logic        TimeoutErr;
    logic [31:0] Remaining;

    int fifo_fill = 0;
    int pop_total = 0;
    int bad_pop   = 0;
    int n_vec     = 0;
    int n_miss    = 0;

    hk_readback_ctrl dut (
        .Clk        (Clk),
        .ARstn      (ARstn),
        .CfgValid   (CfgValid),
        .CfgAddr    (CfgAddr),
        .CfgData    (CfgData),
        .FifoEmpty  (FifoEmpty),
        .RdyWr      (RdyWr),
        .FifoRen    (FifoRen),
        .RWn        (RWn),
        .Busy       (Busy),
        .TimeoutErr (TimeoutErr),
        .Remaining  (Remaining)
    );

    always #5 Clk = ~Clk;

    assign FifoEmpty = (fifo_fill <= pop_total);

    always @(posedge Clk) begin
        if (FifoRen === 1'b1) begin
            pop_total <= pop_total + 1;
            if (!RdyWr || FifoEmpty) bad_pop <= bad_pop + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cfg_write(input logic [23:0] a, input logic [31:0] d);
        CfgValid = 1'b1;
        CfgAddr  = a;
        CfgData  = d;
        step();
        CfgValid = 1'b0;
        CfgAddr  = '0;
        CfgData  = '0;
    endtask

    task automatic load_fifo(input int n);
        fifo_fill = pop_total + n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, b0, k, last_pop, err_edge;

        // Reset values
        step();
        check("rst_ren", FifoRen, 0);
        check("rst_rwn", RWn, 1);
        check("rst_busy", Busy, 0);
        check("rst_err", TimeoutErr, 0);
        check("rst_rem", Remaining, 0);
        step();
        ARstn = 1'b1;
        step();

        // Zero count and foreign address are no-ops in IDLE
        cfg_write(24'h3, 32'h0);
        check("zero_cnt_idle", Busy, 0);
        cfg_write(24'h5, 32'h7);
        check("bad_addr_idle", Busy, 0);

        // Count 5, FIFO 8, RdyWr=1
        load_fifo(8);
        RdyWr = 1'b1;
        p0 = pop_total;
        cfg_write(24'h3, 32'd5);
        check("c5_turn_rwn", RWn, 0);
        check("c5_turn_busy", Busy, 1);
        check("c5_turn_ren", FifoRen, 0);
        check("c5_turn_rem", Remaining, 5);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check($sformatf("c5_pop%0d", i), FifoRen, 1);
            step();
        end
        check("c5_done_rem", Remaining, 0);
        check("c5_done_rwn", RWn, 0);
        check("c5_done_ren", FifoRen, 0);
        step();
        check("c5_idle_rwn", RWn, 1);
        check("c5_idle_busy", Busy, 0);
        check("c5_pops", pop_total - p0, 5);

        // Count 4, RdyWr toggling, FIFO starved for a while
        load_fifo(2);
        p0 = pop_total;
        b0 = bad_pop;
        RdyWr = 1'b0;
        cfg_write(24'h3, 32'd4);
        k = 0;
        while (Busy && k < 40) begin
            RdyWr = ~RdyWr;
            if (k == 10) fifo_fill = fifo_fill + 2;
            step();
            k++;
        end
        check("tog_finished", Busy, 0);
        check("tog_pops", pop_total - p0, 4);
        check("tog_bad_pops", bad_pop - b0, 0);
        check("tog_rem", Remaining, 0);

        // Timeout 10, count 6, FIFO 2
        RdyWr = 1'b1;
        cfg_write(24'h4, 32'd10);
        load_fifo(2);
        p0 = pop_total;
        cfg_write(24'h3, 32'd6);
        last_pop = -1;
        err_edge = -1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge Clk);
            if (FifoRen) last_pop = e;
            step();
            if (TimeoutErr && err_edge < 0) err_edge = e;
            if (!Busy) break;
        end
        check("tmo_last_pop", last_pop, 3);
        check("tmo_err_edge", err_edge, 13);
        check("tmo_pops", pop_total - p0, 2);
        check("tmo_err", TimeoutErr, 1);
        check("tmo_rem", Remaining, 0);
        check("tmo_rwn", RWn, 1);
        cfg_write(24'h4, 32'd0);

        // Count 100, abort after 20 pops with abort coinciding with the 20th
        load_fifo(200);
        p0 = pop_total;
        cfg_write(24'h3, 32'd100);
        check("abt_err_clear", TimeoutErr, 0);
        step();
        repeat (19) step();
        CfgValid = 1'b1;
        CfgAddr  = 24'h3;
        CfgData  = 32'h0;
        @(negedge Clk);
        check("abt_coinc_ren", FifoRen, 1);
        step();
        CfgValid = 1'b0;
        CfgAddr  = '0;
        check("abt_busy", Busy, 0);
        check("abt_rwn", RWn, 1);
        check("abt_rem", Remaining, 0);
        check("abt_err", TimeoutErr, 0);
        check("abt_pops", pop_total - p0, 20);
        repeat (5) step();
        check("abt_no_more_pops", pop_total - p0, 20);

        // Reset mid-XFER
        load_fifo(50);
        p0 = pop_total;
        cfg_write(24'h3, 32'd10);
        repeat (3) step();
        #2 ARstn = 1'b0;
        #1;
        check("mrst_ren", FifoRen, 0);
        check("mrst_rwn", RWn, 1);
        check("mrst_busy", Busy, 0);
        check("mrst_rem", Remaining, 0);
        check("mrst_err", TimeoutErr, 0);
        step();
        step();
        ARstn = 1'b1;
        check("mrst_pops", pop_total - p0, 2);
        load_fifo(10);
        p0 = pop_total;
        cfg_write(24'h3, 32'd3);
        repeat (5) step();
        check("mrst_c3_busy", Busy, 0);
        check("mrst_c3_pops", pop_total - p0, 3);

        // Busy count write ignored, timeout written mid-transfer
        load_fifo(0);
        cfg_write(24'h3, 32'd5);
        step();
        cfg_write(24'h3, 32'd9);
        check("busy_wr_rem", Remaining, 5);
        check("busy_wr_busy", Busy, 1);
        cfg_write(24'h4, 32'd3);
        check("live_tmo_err0", TimeoutErr, 0);
        check("live_tmo_busy", Busy, 1);
        step();
        check("live_tmo_err1", TimeoutErr, 1);
        check("live_tmo_idle", Busy, 0);
        check("live_tmo_rem", Remaining, 0);
        cfg_write(24'h4, 32'd0);

`ifdef HK_READBACK_DRAIN_EN
        // Drain mode: all-ones count empties the FIFO
        load_fifo(7);
        p0 = pop_total;
        cfg_write(24'h3, 32'hFFFF_FFFF);
        repeat (5) step();
        check("drain_rem_held", Remaining, 32'hFFFF_FFFF);
        repeat (4) step();
        check("drain_done_busy", Busy, 1);
        check("drain_done_ren", FifoRen, 0);
        step();
        check("drain_idle", Busy, 0);
        check("drain_pops", pop_total - p0, 7);
`else
        // All-ones is an ordinary count without drain mode
        load_fifo(0);
        cfg_write(24'h3, 32'hFFFF_FFFF);
        check("big_cnt_rem", Remaining, 32'hFFFF_FFFF);
        repeat (3) step();
        check("big_cnt_busy", Busy, 1);
        cfg_write(24'h3, 32'h0);
        check("big_cnt_abort", Busy, 0);
        check("big_cnt_rem0", Remaining, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hk_readback_ctrl.md
HK_READBACK_CTRL -- requirements
Module: hk_readback_ctrl

Interface
REQ-001 SHALL have parameter TMO_W, default 32, the width of the timeout register and counter.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the byte-count register.
REQ-003 SHALL have port Clk  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port ARstn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port CfgValid  in  1  register-write strobe from the command ingress.
REQ-006 SHALL have port CfgAddr  in  24  register-write address.
REQ-007 SHALL have port CfgData  in  32  register-write data.
REQ-008 SHALL have port FifoEmpty  in  1  readback FIFO empty flag.
REQ-009 SHALL have port RdyWr  in  1  FT245 write path ready.
REQ-010 SHALL have port FifoRen  out  1  FIFO pop, which is also Valid_Wr to the FT245 engine.
REQ-011 SHALL have port RWn  out  1  FT245 mode: 1 = host-read (receive), 0 = write-to-host.
REQ-012 SHALL have port Busy  out  1  readback in progress.
REQ-013 SHALL have port TimeoutErr  out  1  sticky flag: the last readback was aborted by timeout.
REQ-014 SHALL have port Remaining  out  CNT_W  bytes still to send.

Function
REQ-015 SHALL decode address 24'h000003 as the byte count and 24'h000004 as the timeout in cycles (CfgData[TMO_W-1:0]); all other addresses are ignored.
REQ-016 SHALL implement states IDLE, TURN, XFER, DONE.
REQ-017 In IDLE, a count write with nonzero data SHALL load Remaining, clear TimeoutErr and go to TURN on the next cycle.
REQ-018 In IDLE, a count write of zero SHALL be a no-op.
REQ-019 TURN SHALL last exactly one cycle with RWn=0 and FifoRen=0 (bus turnaround), then go to XFER.
REQ-020 In XFER, FifoRen SHALL be combinational: ~FifoEmpty & RdyWr & (Remaining!=0).
REQ-021 Each FifoRen cycle SHALL decrement Remaining by 1; the transition Remaining 1->0 SHALL move to DONE.
REQ-022 DONE SHALL last one cycle with RWn=0 and FifoRen=0, then go to IDLE.
REQ-023 RWn SHALL be 0 in TURN/XFER/DONE and 1 in IDLE.
REQ-024 Busy SHALL be 1 whenever the state is not IDLE.
REQ-025 The timeout counter SHALL clear on every FifoRen cycle and on entry to XFER, and SHALL increment on every XFER cycle without FifoRen.
REQ-026 When the timeout counter equals a nonzero timeout register, the block SHALL set TimeoutErr, clear Remaining and go to IDLE on that edge.
REQ-027 A timeout register value of 0 SHALL disable the timeout.
REQ-028 The timeout counter SHALL saturate at all-ones and never wrap.
REQ-029 A count write of zero while Busy SHALL abort: Remaining=0, go to IDLE, TimeoutErr unchanged.
REQ-030 A nonzero count write while Busy SHALL be ignored.
REQ-031 A timeout write SHALL take effect immediately, including mid-transfer.
REQ-032 If CfgValid abort and FifoRen coincide, the pop SHALL complete and the abort SHALL take priority for the next state.

Reset
REQ-033 On ARstn=0 the block SHALL enter IDLE with Remaining=0, timeout register=0, timeout counter=0, TimeoutErr=0, RWn=1, Busy=0, FifoRen=0, asynchronously.
REQ-034 Reset SHALL be deasserted synchronously by the instantiating top.
REQ-035 Reset mid-transfer SHALL discard all state, with no extra pop.

Configuration
REQ-036 When macro HK_READBACK_DRAIN_EN is defined, a count write of 32'hFFFFFFFF SHALL select drain mode: XFER pops until FifoEmpty is seen for one XFER cycle, then goes to DONE; Remaining is held at all-ones and is not decremented.
REQ-037 When HK_READBACK_DRAIN_EN is undefined, 32'hFFFFFFFF SHALL be an ordinary count.

Structure
REQ-038 Package hk_pkg SHALL hold the register address constants (HK_ADDR_LED=1, HK_ADDR_WRSRC=2, HK_ADDR_RDBK_CNT=3, HK_ADDR_RDBK_TMO=4) and the state encoding type.
REQ-039 The timeout counter SHALL be a sub-module hk_timeout_cnt (clear, enable, saturate, compare-equal output).

Verification
REQ-040 Count write 5, FIFO holding 8 bytes, RdyWr=1 -> RWn falls 1 cycle after the write, exactly 5 FifoRen pulses on consecutive cycles, Remaining 0, RWn returns to 1 two cycles after the last pop.
REQ-041 Count 4, RdyWr toggling every cycle -> 4 pops, only on RdyWr=1 cycles, no pop while FifoEmpty=1.
REQ-042 Timeout 10, count 6, FIFO holding 2 bytes -> 2 pops, TimeoutErr=1 exactly 10 cycles after the last pop, Remaining=0, back in IDLE.
REQ-043 Count 100 then a count write of 0 after 20 pops -> IDLE on the next cycle, TimeoutErr=0, no further pops; coincident pop-plus-abort counted once.
REQ-044 ARstn pulsed low mid-XFER -> all outputs at reset values immediately; a new count write of 3 produces 3 pops.
REQ-045 With HK_READBACK_DRAIN_EN defined, count 32'hFFFFFFFF and 7 bytes in the FIFO -> 7 pops, then DONE, then IDLE.
